// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between producer FIFOs, the TX scheduler and the UART serializer.
// The scheduler takes the slave side; producers/transmitter take the master side.
interface uart_tx_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   i_Req_Valid;
    logic [8*NUM_CH-1:0] i_Req_Data;
    logic [NUM_CH-1:0]   o_Req_Ready;
    logic                i_Tx_ClkTick;
    logic                o_Tx_Start;
    logic [7:0]          o_Tx_Data;
    logic                i_Tx_Busy;
    logic [NUM_CH-1:0]   o_Grant;
    logic                o_Active;

    modport master (
        output i_Req_Valid, i_Req_Data, i_Tx_ClkTick, i_Tx_Busy,
        input  o_Req_Ready, o_Tx_Start, o_Tx_Data, o_Grant, o_Active
    );

    modport slave (
        input  i_Req_Valid, i_Req_Data, i_Tx_ClkTick, i_Tx_Busy,
        output o_Req_Ready, o_Tx_Start, o_Tx_Data, o_Grant, o_Active
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NUM_CH producers,
// with optional channel-tag byte and an inter-message gap in TX baud periods.
module uart_tx_scheduler #(
    parameter int NUM_CH    = 4,
    parameter bit TAG_EN    = 1'b1,
    parameter int GAP_TICKS = 2
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SEND_TAG,
        WAIT_TAG,
        SEND_DATA,
        WAIT_DATA,
        GAP
    } state_t;

    state_t            r_State;
    logic [IW-1:0]     r_LastGrant;
    logic [7:0]        r_Byte;
    logic              r_First;
    logic              r_TickQ;
    logic [CW-1:0]     r_GapCnt;
    logic [NUM_CH-1:0] r_Grant;
    logic              r_Tx_Start;
    logic [7:0]        r_Tx_Data;
    logic              r_Active;

    logic [IW-1:0]     w_Win;
    logic              w_Found;
    logic [7:0]        w_WinByte;
    logic [NUM_CH-1:0] w_WinOh;
    logic              w_Accept;
    logic              w_TickRise;

    // Search upward from the channel after the last grant, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_Found = 1'b0;
        w_Win   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(r_LastGrant) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!w_Found && bus.i_Req_Valid[IW'(idx)]) begin
                w_Found = 1'b1;
                w_Win   = IW'(idx);
            end
        end
    end

    always_comb begin
        w_WinByte = '0;
        w_WinOh   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_Win == IW'(k)) begin
                w_WinByte  = bus.i_Req_Data[8*k +: 8];
                w_WinOh[k] = 1'b1;
            end
        end
    end

    assign w_Accept   = (r_State == IDLE) && w_Found && !reset;
    assign w_TickRise = bus.i_Tx_ClkTick & ~r_TickQ;

    assign bus.o_Req_Ready = w_Accept ? w_WinOh : '0;
    assign bus.o_Tx_Start  = r_Tx_Start;
    assign bus.o_Tx_Data   = r_Tx_Data;
    assign bus.o_Grant     = r_Grant;
    assign bus.o_Active    = r_Active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_State     <= IDLE;
            r_LastGrant <= IW'(NUM_CH - 1);
            r_Byte      <= '0;
            r_First     <= 1'b0;
            r_TickQ     <= 1'b0;
            r_GapCnt    <= '0;
            r_Grant     <= '0;
            r_Tx_Start  <= 1'b0;
            r_Tx_Data   <= '0;
            r_Active    <= 1'b0;
        end else begin
            r_TickQ    <= bus.i_Tx_ClkTick;
            r_Tx_Start <= 1'b0;
            unique case (r_State)
                IDLE: begin
                    if (w_Accept) begin
                        r_Byte      <= w_WinByte;
                        r_LastGrant <= w_Win;
                        r_Grant     <= w_WinOh;
                        r_Active    <= 1'b1;
                        r_Tx_Start  <= 1'b1;
                        if (TAG_EN) begin
                            r_Tx_Data <= 8'hF0 + 8'(w_Win);
                            r_State   <= SEND_TAG;
                        end else begin
                            r_Tx_Data <= w_WinByte;
                            r_State   <= SEND_DATA;
                        end
                    end
                end
                SEND_TAG: begin
                    r_First <= 1'b1;
                    r_State <= WAIT_TAG;
                end
                WAIT_TAG: begin
                    r_First <= 1'b0;
                    // Busy may not have risen yet in the first wait cycle.
                    if (!r_First && !bus.i_Tx_Busy) begin
                        r_Tx_Start <= 1'b1;
                        r_Tx_Data  <= r_Byte;
                        r_State    <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    r_First <= 1'b1;
                    r_State <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    r_First <= 1'b0;
                    if (!r_First && !bus.i_Tx_Busy) begin
                        if (GAP_TICKS > 0) begin
                            r_GapCnt <= '0;
                            r_State  <= GAP;
                        end else begin
                            r_Grant  <= '0;
                            r_Active <= 1'b0;
                            r_State  <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (w_TickRise) begin
                        if (r_GapCnt == GAP_LAST) begin
                            r_GapCnt <= '0;
                            r_Grant  <= '0;
                            r_Active <= 1'b0;
                            r_State  <= IDLE;
                        end else begin
                            r_GapCnt <= r_GapCnt + 1'b1;
                        end
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end
endmodule
